maxpool2d_stream: RTL

Streaming 2-D max-pooling unit for the NPU post-convolution path, the parametrised successor of the fixed 8-bit pooling block. Accepts one pixel per enabled cycle in raster order. Reduces non-overlapping POOL×POOL windows (stride = POOL) using an internal partial-result line buffer. Emits one pooled pixel per completed window, and can bypass pooling entirely so the stream passes straight through.

---
 rtl/maxpool2d_stream.sv | 114 +++++++++++
 1 files changed

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: streaming POOLxPOOL max-pool (stride POOL) with bypass; optional MAXPOOL_AVG_EN adds average pooling
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in, en     raster-order pixel stream, one pixel per en beat, no backpressure
//   en_mp      1 = pool, 0 = bypass; latched on the first beat of a frame
//   avg_sel    (MAXPOOL_AVG_EN only) 1 = sum/average instead of max; latched with en_mp
//   out,out_en pooled (or bypassed) pixel with its one-cycle valid strobe
//   frame_done pulse with the output of the frame's last input beat
module maxpool2d_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 6,
   parameter int IMG_H  = 6,
   parameter int POOL   = 2,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   input  logic              en,
   input  logic              en_mp,
`ifdef MAXPOOL_AVG_EN
   input  logic              avg_sel,
`endif
   output logic [DATA_W-1:0] out,
   output logic              out_en,
   output logic              frame_done
);
   localparam int LP = $clog2(POOL);
   localparam int NB = IMG_W / POOL;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int IW = NB > 1 ? $clog2(NB) : 1;
`ifdef MAXPOOL_AVG_EN
   localparam int AW = DATA_W + 2 * LP;
`else
   localparam int AW = DATA_W;
`endif
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [LP-1:0] hcnt, vcnt;
   logic [IW-1:0] idx;
   logic          mode_r, mode, avg, first, last, h_end, v_end;
   logic [AW-1:0] hacc, x, h, v, lb_rd, pooled;
   logic signed [AW-1:0] v_sra;
   logic [AW-1:0] lb [NB];
   // avg=1 sums, otherwise keeps the larger operand under the configured signedness
   function automatic logic [AW-1:0] red(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic s);
      red = s ? a + b : ((SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
   endfunction
   assign hcnt  = col[LP-1:0];
   assign vcnt  = row[LP-1:0];
   assign idx   = IW'(col >> LP);
   assign first = col == '0 && row == '0;
   assign last  = col == CW'(IMG_W - 1) && row == RW'(IMG_H - 1);
   assign h_end = hcnt == LP'(POOL - 1);
   assign v_end = vcnt == LP'(POOL - 1);
   // the first beat of a frame already obeys the mode it latches
   assign mode  = first ? en_mp : mode_r;
`ifdef MAXPOOL_AVG_EN
   logic avg_r;
   assign avg = first ? avg_sel : avg_r;
`else
   assign avg = 1'b0;
`endif
   // widen the pixel so sums cannot overflow; sign-extension keeps signed order intact
   assign x      = (SIGNED != 0) ? AW'($signed(in)) : AW'(in);
   assign h      = red(hacc, x, avg);
   assign lb_rd  = lb[idx];
   assign v      = red(lb_rd, h, avg);
   assign v_sra  = $signed(v) >>> (2 * LP);
   assign pooled = !avg ? v : (SIGNED != 0) ? v_sra : v >> (2 * LP);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         col        <= '0;
         row        <= '0;
         hacc       <= '0;
         mode_r     <= 1'b1;
         out        <= '0;
         out_en     <= 1'b0;
         frame_done <= 1'b0;
`ifdef MAXPOOL_AVG_EN
         avg_r      <= 1'b0;
`endif
      end else begin
         out_en     <= 1'b0;
         frame_done <= 1'b0;
         if (en) begin
            col <= col == CW'(IMG_W - 1) ? '0 : col + 1'b1;
            if (col == CW'(IMG_W - 1))
               row <= row == RW'(IMG_H - 1) ? '0 : row + 1'b1;
            if (first) begin
               mode_r <= en_mp;
`ifdef MAXPOOL_AVG_EN
               avg_r  <= avg_sel;
`endif
            end
            if (mode)
               hacc <= hcnt == '0 ? x : h;
            if (!mode) begin
               out        <= in;
               out_en     <= 1'b1;
               frame_done <= last;
            end else if (h_end && v_end) begin
               out        <= pooled[DATA_W-1:0];
               out_en     <= 1'b1;
               frame_done <= last;
            end
         end
      end
   // row 0 of a window band overwrites, so stale entries never need clearing
   always_ff @(posedge clk)
      if (en && mode && h_end && !v_end)
         lb[idx] <= vcnt == '0 ? h : v;
endmodule
